button_debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-button debouncer. It synchronises NUM_CH raw button/switch inputs and filters each one with a saturating up/down integrator that has hysteresis. It produces a debounced level, one-cycle press and release pulses, and a one-shot long-press pulse per channel. All channels share one tick prescaler. It sits between board pins and the control FSMs/display logic.

---
 rtl/button_debounce_multi.sv | 145 ++++++++++++++
 tb/tb_button_debounce_multi.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_multi.sv
// ---------------------------------------------------------------------------
// button_debounce_multi
//
// Multi-channel button/switch debouncer. Each raw input goes through a
// two-flop synchroniser and then a saturating up/down integrator that is
// advanced only on a shared sample tick. The integrator has hysteresis:
// the debounced level sets when the integrator reaches THRESH and clears
// when it reaches 0. For each channel the block also produces one-cycle
// press (rise) and release (fall) pulses, and a one-shot long-press (hold)
// pulse.
//
// Handshake: none. The inputs are free-running levels and every output is
// a registered level or a single-cycle strobe. There is no valid/ready
// pairing.
//
// Ports
//   clk     : system clock
//   reset   : asynchronous, active-high reset; clears all state
//   btn_in  : [NUM_CH] raw asynchronous inputs, active-high
//   level_o : [NUM_CH] debounced level
//   rise_o  : [NUM_CH] one-cycle pulse, first cycle level_o reads 1
//   fall_o  : [NUM_CH] one-cycle pulse, first cycle level_o reads 0
//   hold_o  : [NUM_CH] one-cycle pulse after HOLD_TICKS ticks of level high
//   tick_o  : shared sample strobe (prescaler at zero)
// ---------------------------------------------------------------------------
module button_debounce_multi #(
   parameter int NUM_CH     = 4,
   parameter int CLK_DIV    = 100000,
   parameter int THRESH     = 3,
   parameter int HOLD_TICKS = 100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic [NUM_CH-1:0] hold_o,
   output logic              tick_o
);

   localparam int DIV_W  = $clog2(CLK_DIV);
   localparam int CNT_W  = $clog2(THRESH + 1);
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_TOP  = CNT_W'(THRESH);
   localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_TICKS - 1);

   logic [DIV_W-1:0]  div_cnt;
   logic              tick;
   logic [NUM_CH-1:0] sync_a;
   logic [NUM_CH-1:0] sync_s;

   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  cnt_nx  [NUM_CH];
   logic [HOLD_W-1:0] hcnt    [NUM_CH];
   logic [HOLD_W-1:0] hcnt_nx [NUM_CH];
   logic [NUM_CH-1:0] lvl_nx;
   logic [NUM_CH-1:0] rise_nx;
   logic [NUM_CH-1:0] fall_nx;
   logic [NUM_CH-1:0] hold_nx;

   // Shared prescaler: one sample tick every CLK_DIV clocks. Because it
   // resets to 0, the first tick lands on the first cycle after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign tick = (div_cnt == '0);
   // Masked while reset is held so every output reads 0 in reset.
   assign tick_o = tick & ~reset;

   // Per-channel next-state. The level is derived from the next integrator
   // value so it flips on the same edge the integrator hits an end stop.
   // rise/fall are computed from the next level so they appear in the very
   // cycle level_o first shows the new value.
   always_comb begin
      lvl_nx  = level_o;
      hold_nx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_nx[i]  = cnt[i];
         hcnt_nx[i] = hcnt[i];

         if (tick) begin
            if (sync_s[i] && (cnt[i] < CNT_TOP)) begin
               cnt_nx[i] = cnt[i] + 1'b1;
            end else if (!sync_s[i] && (cnt[i] != '0)) begin
               cnt_nx[i] = cnt[i] - 1'b1;
            end
         end

         if (cnt_nx[i] == CNT_TOP) begin
            lvl_nx[i] = 1'b1;
         end else if (cnt_nx[i] == '0) begin
            lvl_nx[i] = 1'b0;
         end

         // Hold counter only runs while the debounced level is high, so a
         // release always re-arms the one-shot for the next press.
         if (!level_o[i]) begin
            hcnt_nx[i] = '0;
         end else if (tick && (hcnt[i] != HOLD_TOP)) begin
            hcnt_nx[i] = hcnt[i] + 1'b1;
            hold_nx[i] = (hcnt[i] == HOLD_PRE);
         end
      end
      rise_nx = lvl_nx & ~level_o;
      fall_nx = ~lvl_nx & level_o;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_a  <= '0;
         sync_s  <= '0;
         level_o <= '0;
         rise_o  <= '0;
         fall_o  <= '0;
         hold_o  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= '0;
            hcnt[i] <= '0;
         end
      end else begin
         sync_a  <= btn_in;
         sync_s  <= sync_a;
         level_o <= lvl_nx;
         rise_o  <= rise_nx;
         fall_o  <= fall_nx;
         hold_o  <= hold_nx;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= cnt_nx[i];
            hcnt[i] <= hcnt_nx[i];
         end
      end
   end

endmodule

// File: tb/tb_button_debounce_multi.sv
// ---------------------------------------------------------------------------
// Testbench for button_debounce_multi (NUM_CH=2, CLK_DIV=4, THRESH=3,
// HOLD_TICKS=5). Inputs change 2 time units after a rising edge; outputs
// are checked on the falling edge against a tick-level behavioural model,
// plus directed literal checks for latency windows and pulse counts.
// ---------------------------------------------------------------------------
module tb_button_debounce_multi;

   localparam int NUM_CH     = 2;
   localparam int CLK_DIV    = 4;
   localparam int THRESH     = 3;
   localparam int HOLD_TICKS = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] btn_in;
   logic [NUM_CH-1:0] level_o, rise_o, fall_o, hold_o;
   logic              tick_o;

   int tests = 0;
   int fails = 0;

   button_debounce_multi #(
      .NUM_CH(NUM_CH), .CLK_DIV(CLK_DIV), .THRESH(THRESH), .HOLD_TICKS(HOLD_TICKS)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in),
      .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o), .hold_o(hold_o),
      .tick_o(tick_o)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

   // ---------------- checker ----------------
   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got=%0d want=%0d", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Works in plain integers: input delayed by two samples, integrator as a
   // clamped count, level with hysteresis, hold as "ticks spent high".
   int                m_int  [NUM_CH];
   int                m_high [NUM_CH];
   logic [NUM_CH-1:0] m_lvl, m_rise, m_fall, m_hold;
   logic [NUM_CH-1:0] m_hist0, m_hist1, m_s;
   logic              m_tk, m_new;
   int                ncyc;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < NUM_CH; c++) begin
            m_int[c]  = 0;
            m_high[c] = 0;
         end
         m_lvl = '0; m_rise = '0; m_fall = '0; m_hold = '0;
         m_hist0 = '0; m_hist1 = '0;
         ncyc = 0;
      end else begin
         m_tk    = ((ncyc % CLK_DIV) == 0);
         m_s     = m_hist1;
         m_hist1 = m_hist0;
         m_hist0 = btn_in;
         for (int c = 0; c < NUM_CH; c++) begin
            m_hold[c] = 1'b0;
            if (!m_lvl[c]) m_high[c] = 0;
            else if (m_tk && m_high[c] < HOLD_TICKS) begin
               m_high[c] = m_high[c] + 1;
               m_hold[c] = (m_high[c] == HOLD_TICKS);
            end
            if (m_tk) begin
               if (m_s[c]) m_int[c] = (m_int[c] + 1 > THRESH) ? THRESH : m_int[c] + 1;
               else        m_int[c] = (m_int[c] - 1 < 0) ? 0 : m_int[c] - 1;
            end
            if (m_int[c] == THRESH) m_new = 1'b1;
            else if (m_int[c] == 0) m_new = 1'b0;
            else                    m_new = m_lvl[c];
            m_rise[c] = m_new & ~m_lvl[c];
            m_fall[c] = ~m_new & m_lvl[c];
            m_lvl[c]  = m_new;
         end
         ncyc++;
      end
   end

   // ---------------- scoreboard / monitor ----------------
   int   edge_n = 0;
   int   rise_cnt [NUM_CH];
   int   fall_cnt [NUM_CH];
   int   hold_cnt [NUM_CH];
   int   rise_edge[NUM_CH];
   int   hold_edge[NUM_CH];
   logic both_seen;

   always @(posedge clk) edge_n++;

   always @(negedge clk) begin
      chk("model_level", level_o, m_lvl);
      chk("model_rise",  rise_o,  m_rise);
      chk("model_fall",  fall_o,  m_fall);
      chk("model_hold",  hold_o,  m_hold);
      chk("model_tick",  tick_o,  (!reset && ((ncyc % CLK_DIV) == 0)) ? 1 : 0);
      for (int c = 0; c < NUM_CH; c++) begin
         if (rise_o[c]) begin rise_cnt[c]++; rise_edge[c] = edge_n; end
         if (fall_o[c]) fall_cnt[c]++;
         if (hold_o[c]) begin hold_cnt[c]++; hold_edge[c] = edge_n; end
      end
      if (rise_o == 2'b11) both_seen = 1'b1;
   end

   // ---------------- driver tasks ----------------
   task automatic clr_counts();
      for (int c = 0; c < NUM_CH; c++) begin
         rise_cnt[c] = 0; fall_cnt[c] = 0; hold_cnt[c] = 0;
         rise_edge[c] = 0; hold_edge[c] = 0;
      end
      both_seen = 1'b0;
   endtask

   // Leaves the caller 2 time units after a rising edge.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Hold a value for exactly one tick period (one tick sample).
   task automatic win(input logic [NUM_CH-1:0] v);
      btn_in = v;
      edges(CLK_DIV);
   endtask

   // Count rising edges until level_o[ch] equals want; bounded.
   task automatic wait_level(input int ch, input logic want, output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (level_o[ch] == want) break;
      end
   endtask

   // ---------------- stimulus ----------------
   int n;

   initial begin
      btn_in = '0;
      reset  = 1'b0;
      clr_counts();
      #1 reset = 1'b1;
      edges(3);
      reset = 1'b0;

      // Idle: tick every 4th cycle from cycle 0, all outputs low.
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         chk("idle_tick_sched", tick_o, (k % 4 == 0) ? 1 : 0);
         chk("idle_outputs", {level_o, rise_o, fall_o, hold_o}, 0);
      end
      edges(1);

      // Clean step on ch0 + long hold.
      clr_counts();
      btn_in = 2'b01;
      wait_level(0, 1'b1, n);
      chk("step_rise_latency_11_14", (n >= 11 && n <= 14) ? n : -n, n);
      chk("step_rise_pulse", rise_o[0], 1);
      chk("step_ch1_idle", level_o[1], 0);
      @(negedge clk);
      chk("step_rise_one_cycle", rise_o[0], 0);
      edges(60);
      chk("hold_once", hold_cnt[0], 1);
      chk("hold_delay_5_ticks", hold_edge[0] - rise_edge[0], HOLD_TICKS * CLK_DIV);
      edges(100);
      chk("hold_not_again", hold_cnt[0], 1);
      chk("ch1_untouched", rise_cnt[1], 0);

      // Release, then press again to re-arm the hold one-shot.
      btn_in = 2'b00;
      wait_level(0, 1'b0, n);
      chk("release_fall_latency_11_14", (n >= 11 && n <= 14) ? n : -n, n);
      chk("release_fall_pulse", fall_o[0], 1);
      edges(2);
      btn_in = 2'b01;
      edges(60);
      chk("hold_rearmed", hold_cnt[0], 2);
      chk("rise_count_two_presses", rise_cnt[0], 2);
      btn_in = 2'b00;
      edges(40);

      // Bounce: per-tick samples 1,1,0,1,1 -> rises only on the 5th tick.
      clr_counts();
      win(2'b01); win(2'b01); win(2'b00); win(2'b01);
      chk("bounce_no_early_rise", rise_cnt[0], 0);
      chk("bounce_level_low", level_o[0], 0);
      win(2'b01);
      btn_in = 2'b00;
      edges(3);
      chk("bounce_rise_at_5th", rise_cnt[0], 1);
      edges(4);
      chk("bounce_hysteresis_hold", level_o[0], 1);
      edges(40);
      chk("bounce_fall", fall_cnt[0], 1);

      // Short burst: two high ticks then low -> no change.
      clr_counts();
      win(2'b01); win(2'b01);
      btn_in = 2'b00;
      edges(40);
      chk("burst_no_rise", rise_cnt[0], 0);
      chk("burst_level_low", level_o[0], 0);

      // Both channels in the same cycle.
      clr_counts();
      btn_in = 2'b11;
      wait_level(1, 1'b1, n);
      edges(2);
      chk("both_rise_same_cycle", both_seen, 1);
      chk("both_rise_ch1", rise_cnt[1], 1);
      btn_in = 2'b00;
      edges(40);

      // Reset while level high with integrator mid-band.
      btn_in = 2'b01;
      edges(24);
      win(2'b00);
      chk("pre_reset_level_midband", level_o[0], 1);
      clr_counts();
      btn_in = 2'b01;
      #1 reset = 1'b1;
      #1;
      chk("async_reset_outputs", {level_o, rise_o, fall_o, hold_o}, 0);
      edges(3);
      reset = 1'b0;
      wait_level(0, 1'b1, n);
      chk("post_reset_rise_edge13", n, 13);
      chk("post_reset_no_fall", fall_cnt[0], 0);
      edges(4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
